// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Brief    : Bit-serial two's-complement subtractor (Diff = A - B), one bit
//             per clock, LSB first, with a start/busy/done handshake.
//             Operand convention: index 0 = MSB, index WIDTH-1 = LSB.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [0:WIDTH-1] A,
    input  logic [0:WIDTH-1] B,
    output logic [0:WIDTH-1] Diff,
    output logic             Borrow,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done
);

    localparam int c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    // The minuend register doubles as the result shift register: each
    // processed operand bit leaves at the LSB end while the difference bit
    // enters at the MSB end, so after WIDTH steps it holds the full result.
    logic [0:WIDTH-1]   r_a_sh;
    logic [0:WIDTH-1]   r_b_sh;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_br;

    logic               w_a;
    logic               w_b;
    logic               w_d;
    logic               w_br_nxt;
    logic               w_last;

    // Full-subtractor cell on the current LSB-end bits
    always_comb begin
        w_a      = r_a_sh[WIDTH-1];
        w_b      = r_b_sh[WIDTH-1];
        w_d      = w_a ^ w_b ^ r_br;
        w_br_nxt = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
        w_last   = (r_cnt == c_LAST);
    end

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start only from IDLE, finish on the MSB step
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (En) w_state_nxt = c_RUN;
            c_RUN:   if (w_last) w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Datapath: operand capture, serial shift/borrow chain, result commit
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_cnt    <= '0;
            r_br     <= 1'b0;
            Diff     <= '0;
            Borrow   <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (En) begin
                        r_a_sh <= A;
                        r_b_sh <= B;
                        r_cnt  <= '0;
                        r_br   <= 1'b0;
                    end
                end
                c_RUN: begin
                    r_a_sh <= {w_d, r_a_sh[0:WIDTH-2]};
                    r_b_sh <= {1'b0, r_b_sh[0:WIDTH-2]};
                    r_br   <= w_br_nxt;
                    r_cnt  <= r_cnt + c_ONE;
                    if (w_last) begin
                        // MSB step: signed overflow is borrow-in xor borrow-out
                        Diff     <= {w_d, r_a_sh[0:WIDTH-2]};
                        Borrow   <= w_br_nxt;
                        Overflow <= r_br ^ w_br_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake flags decode straight from the state register
    always_comb begin
        Busy = (r_state == c_RUN);
        Done = (r_state == c_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Brief    : Self-checking bench for serial_subtractor against an arithmetic
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 4;

    logic         Clk;
    logic         Reset;
    logic         En;
    logic [0:W-1] A;
    logic [0:W-1] B;
    logic [0:W-1] Diff;
    logic         Borrow;
    logic         Overflow;
    logic         Busy;
    logic         Done;

    int n_tests;
    int n_fail;
    int e_d, e_b, e_o;   // expected result of the operation in flight
    int h_d, h_b, h_o;   // result the outputs must currently hold

    serial_subtractor #(.WIDTH(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .En       (En),
        .A        (A),
        .B        (B),
        .Diff     (Diff),
        .Borrow   (Borrow),
        .Overflow (Overflow),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views
    task automatic model(input int a, input int b);
        int m, sa, sb, sd;
        m   = 1 << W;
        e_d = ((a - b) % m + m) % m;
        e_b = (a < b) ? 1 : 0;
        sa  = (a >= m / 2) ? a - m : a;
        sb  = (b >= m / 2) ? b - m : b;
        sd  = sa - sb;
        e_o = (sd > m / 2 - 1 || sd < -(m / 2)) ? 1 : 0;
    endtask

    // Called at #1 after an edge with the DUT idle; returns #1 after capture edge
    task automatic start_op(input int a, input int b, input bit keep_en);
        model(a, b);
        A  = W'(a);
        B  = W'(b);
        En = 1'b1;
        @(posedge Clk); #1;
        if (!keep_en) En = 1'b0;
    endtask

    // Operands are scrambled every cycle to show the captured copy is used
    task automatic complete_op(input string tag);
        for (int i = 0; i < W; i++) begin
            check({tag, " busy"}, Busy, 1);
            check({tag, " done-early"}, Done, 0);
            check({tag, " diff-hold"}, Diff, h_d);
            check({tag, " borrow-hold"}, Borrow, h_b);
            check({tag, " ovf-hold"}, Overflow, h_o);
            A = W'($urandom);
            B = W'($urandom);
            @(posedge Clk); #1;
        end
        check({tag, " done"}, Done, 1);
        check({tag, " busy-off"}, Busy, 0);
        check({tag, " diff"}, Diff, e_d);
        check({tag, " borrow"}, Borrow, e_b);
        check({tag, " ovf"}, Overflow, e_o);
        h_d = e_d; h_b = e_b; h_o = e_o;
        @(posedge Clk); #1;
        check({tag, " done-pulse"}, Done, 0);
        check({tag, " busy-idle"}, Busy, 0);
        check({tag, " diff-after"}, Diff, h_d);
    endtask

    task automatic run_op(input int a, input int b, input string tag);
        start_op(a, b, 1'b0);
        complete_op(tag);
    endtask

    initial begin
        int ra, rb;
        n_tests = 0; n_fail = 0;
        h_d = 0; h_b = 0; h_o = 0;
        Reset = 1'b1; En = 1'b0; A = '0; B = '0;
        @(posedge Clk); #1;
        check("rst diff", Diff, 0);
        check("rst borrow", Borrow, 0);
        check("rst ovf", Overflow, 0);
        check("rst busy", Busy, 0);
        check("rst done", Done, 0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;
        check("idle busy", Busy, 0);

        // Basic, borrow, zero and overflow cases
        run_op(4'b0011, 4'b0001, "t1");
        run_op(4'b0011, 4'b1111, "t2a");
        run_op(4'b0000, 4'b0000, "t2b");
        run_op(4'b1000, 4'b0001, "t3a");
        run_op(4'b0111, 4'b1111, "t3b");

        // En held high and operands churning through RUN and DONE
        start_op(4'b0101, 4'b0010, 1'b1);
        complete_op("t4a");
        start_op(4'b1001, 4'b0011, 1'b0);
        complete_op("t4b");

        // Asynchronous reset between edges k+2 and k+3 aborts the operation
        start_op(4'b1111, 4'b0001, 1'b0);
        @(posedge Clk); #1;
        @(posedge Clk); #2;
        Reset = 1'b1;
        #1;
        check("t5 rst diff", Diff, 0);
        check("t5 rst borrow", Borrow, 0);
        check("t5 rst ovf", Overflow, 0);
        check("t5 rst busy", Busy, 0);
        check("t5 rst done", Done, 0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        h_d = 0; h_b = 0; h_o = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge Clk); #1;
            check("t5 no-done", Done, 0);
            check("t5 no-busy", Busy, 0);
        end
        run_op(4'b1111, 4'b0001, "t5 fresh");

        // Exhaustive sweep back-to-back
        for (int i = 0; i < (1 << (2 * W)); i++) begin
            run_op(i >> W, i % (1 << W), "sweep");
        end

        // Random operands
        for (int i = 0; i < 40; i++) begin
            ra = int'($urandom_range((1 << W) - 1, 0));
            rb = int'($urandom_range((1 << W) - 1, 0));
            run_op(ra, rb, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor, computing Diff = A - B one bit per clock, LSB first.
- Performs the inverse operation of the team's 4-bit adder, with the same operand convention: index 0 = MSB, index WIDTH-1 = LSB.
- Start/done handshake lets a controller or testbench launch one operation at a time.
- Result and flags are held stable between operations.

Parameters:
WIDTH, 4, operand/result width in bits (WIDTH >= 2)

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
En  input  1  start request; sampled only in IDLE
A  input  [0:WIDTH-1]  minuend; index 0 = MSB
B  input  [0:WIDTH-1]  subtrahend; index 0 = MSB
Diff  output  [0:WIDTH-1]  registered result A - B mod 2^WIDTH
Borrow  output  1  unsigned borrow-out (1 when A < B unsigned)
Overflow  output  1  signed two's-complement overflow
Busy  output  1  high while an operation is in progress
Done  output  1  one-cycle pulse when Diff/Borrow/Overflow update

Behaviour:
- Reset (async, active-high) forces the following, regardless of state, and aborts any operation in progress:
  - state = IDLE
  - Diff = 0, Borrow = 0, Overflow = 0, Busy = 0, Done = 0
  - internal shift registers, bit counter and running borrow = 0
- States: IDLE, RUN, DONE.
- IDLE:
  - En=1 at a rising edge captures A and B into internal shift registers, clears the running borrow and counter, and moves to RUN.
  - Busy=1 from that edge onward.
  - En=0: stay in IDLE.
- RUN: one bit per edge, starting at index WIDTH-1. With a, b = current operand bits and br = running borrow:
  - d = a ^ b ^ br
  - br' = (~a & b) | (~(a ^ b) & br)
  - d shifts into a result shift register; the counter increments.
  - While processing index 0 (the MSB), capture ovf = br_in ^ br_out for that bit.
- After WIDTH RUN edges (the edge that processes the MSB):
  - Diff <= assembled result, Borrow <= final br', Overflow <= ovf
  - Done = 1, Busy = 0, state = DONE.
- DONE lasts exactly one cycle; the next edge returns to IDLE with Done = 0.
- Latency: if En is sampled at edge k, then Busy=1 after edges k..k+WIDTH-1, and results plus Done=1 appear after edge k+WIDTH. The earliest next start is edge k+WIDTH+2.
- En is ignored in RUN and DONE; no queuing.
- Changes on A/B after the capture edge must not affect the in-flight result.
- Diff/Borrow/Overflow hold the last completed result until the next completion. They do not change during RUN.
- Busy and Done are never high simultaneously.
- Identities: equal operands give Diff=0, Borrow=0, Overflow=0. B=0 gives Diff=A, Borrow=0, Overflow=0.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset asserted, then released; A=0011, B=0001, En pulse at edge k -> Busy high for 4 cycles; after edge k+4: Diff=0010, Borrow=0, Overflow=0, Done=1 for exactly one cycle; Done=0 after edge k+5.
2. A=0011, B=1111 -> Diff=0100, Borrow=1, Overflow=0. A=0000, B=0000 -> Diff=0000, all flags 0.
3. Overflow cases:
   - A=1000, B=0001 (-8-1) -> Diff=0111, Borrow=0, Overflow=1.
   - A=0111, B=1111 (7-(-1)) -> Diff=1000, Borrow=1, Overflow=1.
4. Start A=0101, B=0010, then hold En=1 and change A/B every cycle during RUN and DONE -> single Done; Diff=0011; next operation starts no earlier than edge k+6 using the A/B present then.
5. Start A=1111, B=0001; assert Reset asynchronously between edges k+2 and k+3 -> all outputs 0 immediately (before the next edge); no Done pulse; after release, a fresh operation completes correctly.
6. Sweep all 256 A/B pairs (WIDTH=4) back-to-back with a scoreboard -> Diff, Borrow and Overflow match the reference model on every Done; Busy/Done never overlap.
